// File: rtl/mul32x32_slice_seq_if.sv
// Operand/result handshake bundle for mul32x32_slice_seq.
//   in_valid/in_ready : operand pair handshake, in_a/in_b carry the unsigned operands
//   out_valid/out_ready : product handshake, out_p carries the 64-bit product
// master = producer of operands / consumer of products; slave = the multiplier controller.
interface mul32x32_slice_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/mul32x32_slice_seq.sv
// Sequential 32x32 unsigned multiplier controller. Feeds an external 32x8 array multiplier
// one byte of B per cycle and shift-accumulates its 40-bit partial products into 64 bits.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : operand/result handshakes (slave side of mul32x32_slice_seq_if)
//   mul_a      : 32-bit A operand to the array multiplier
//   mul_b      : 8-bit B slice to the array multiplier
//   mul_y      : 40-bit combinational product back from the array multiplier
//   busy       : high while an operation is running or its result is pending
// SKIP_ZERO != 0 finishes early once all remaining upper bytes of B are zero.
module mul32x32_slice_seq #(
   parameter int unsigned SKIP_ZERO = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   mul32x32_slice_seq_if.slave       bus,
   output logic [31:0]               mul_a,
   output logic [7:0]                mul_b,
   input  logic [39:0]               mul_y,
   output logic                      busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q;
   logic [1:0]  idx_q;
   logic [63:0] acc_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] p_q;
   logic        out_valid_q;
   logic        in_ready_q;
   logic        busy_q;

   logic [7:0]  slice;
   logic        upper_zero;
   logic        last_slice;
   logic [63:0] acc_sum;

   always_comb begin
      slice      = b_q[{idx_q, 3'b000} +: 8];
      upper_zero = 1'b0;
      case (idx_q)
         2'd0:    upper_zero = (b_q[31:8] == 24'd0);
         2'd1:    upper_zero = (b_q[31:16] == 16'd0);
         2'd2:    upper_zero = (b_q[31:24] == 8'd0);
         default: upper_zero = 1'b1;
      endcase
      last_slice = (idx_q == 2'd3) || ((SKIP_ZERO != 0) && upper_zero);
      // Partial product weighted by its byte position; 40 bits << 24 still fits in 64.
      acc_sum    = acc_q + ({24'd0, mul_y} << {idx_q, 3'b000});
   end

   // Multiplier inputs are decoded from registers only, and forced to zero outside RUN.
   assign mul_a = (state_q == StRun) ? a_q : 32'd0;
   assign mul_b = (state_q == StRun) ? slice : 8'd0;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = p_q;
   assign busy          = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= 2'd0;
         acc_q       <= 64'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         p_q         <= 64'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.in_a;
                  b_q        <= bus.in_b;
                  acc_q      <= 64'd0;
                  idx_q      <= 2'd0;
                  state_q    <= StRun;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StRun: begin
               acc_q <= acc_sum;
               idx_q <= idx_q + 2'd1;
               if (last_slice) begin
                  // Separate result register so out_p survives the next accept.
                  p_q         <= acc_sum;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul32x32_slice_seq.sv
// Directed bench for mul32x32_slice_seq. Two instances (SKIP_ZERO=1 and SKIP_ZERO=0) share
// the same operand/result stimulus; each gets its own behavioural 32x8 multiplier.
module tb_mul32x32_slice_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_ready = 1'b0;

   mul32x32_slice_seq_if bus_s ();
   mul32x32_slice_seq_if bus_n ();

   assign bus_s.in_valid  = in_valid;
   assign bus_s.in_a      = in_a;
   assign bus_s.in_b      = in_b;
   assign bus_s.out_ready = out_ready;
   assign bus_n.in_valid  = in_valid;
   assign bus_n.in_a      = in_a;
   assign bus_n.in_b      = in_b;
   assign bus_n.out_ready = out_ready;

   logic [31:0] mul_a_s, mul_a_n;
   logic [7:0]  mul_b_s, mul_b_n;
   logic [39:0] mul_y_s, mul_y_n;
   logic        busy_s, busy_n;

   // External 32x8 array multiplier: combinational, same-cycle result.
   assign mul_y_s = 40'(mul_a_s) * 40'(mul_b_s);
   assign mul_y_n = 40'(mul_a_n) * 40'(mul_b_n);

   mul32x32_slice_seq #(.SKIP_ZERO(1)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s),
      .mul_a (mul_a_s),
      .mul_b (mul_b_s),
      .mul_y (mul_y_s),
      .busy  (busy_s)
   );

   mul32x32_slice_seq #(.SKIP_ZERO(0)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_n),
      .mul_a (mul_a_n),
      .mul_b (mul_b_n),
      .mul_y (mul_y_n),
      .busy  (busy_n)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] seq [4];
   int         nrun;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One operation with out_ready=1 on both instances. Latencies use the accept edge as
   // cycle 0 and name the cycle at whose edge out_valid is first seen high.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_lat_s, input int exp_lat_n,
                         input int exp_nrun);
      int lat_s, lat_n;
      logic [63:0] p_s, p_n;
      lat_s = 0;
      lat_n = 0;
      p_s   = '0;
      p_n   = '0;
      nrun  = 0;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, 64'(bus_s.in_ready), 64'd1);
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 32'hA5A5_5A5A;
      in_b     = 32'h5A5A_A5A5;
      for (int n = 0; n < 20; n++) begin
         if (n > 0) @(negedge clk);
         if (busy_s && !bus_s.out_valid) begin
            if (nrun < 4) seq[nrun] = mul_b_s;
            nrun++;
         end
         if (bus_s.out_valid && lat_s == 0) begin
            lat_s = n + 1;
            p_s   = bus_s.out_p;
         end
         if (bus_n.out_valid && lat_n == 0) begin
            lat_n = n + 1;
            p_n   = bus_n.out_p;
         end
         if (lat_s != 0 && lat_n != 0) break;
      end
      check_eq({tag, "_p_skip"}, p_s, exp_p);
      check_eq({tag, "_p_full"}, p_n, exp_p);
      check_eq({tag, "_lat_skip"}, 64'(lat_s), 64'(exp_lat_s));
      check_eq({tag, "_lat_full"}, 64'(lat_n), 64'(exp_lat_n));
      check_eq({tag, "_nrun"}, 64'(nrun), 64'(exp_nrun));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs1, acc2, outs;
      logic [63:0] p1, p2;

      // Reset state.
      #12;
      check_eq("rst_out_valid", 64'(bus_s.out_valid), 64'd0);
      check_eq("rst_out_p", bus_s.out_p, 64'd0);
      check_eq("rst_mul_a", 64'(mul_a_s), 64'd0);
      check_eq("rst_mul_b", 64'(mul_b_s), 64'd0);
      check_eq("rst_busy", 64'(busy_s), 64'd0);
      check_eq("rst_in_ready", 64'(bus_s.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 5, 4);
      for (int i = 0; i < 4; i++) check_eq($sformatf("ffff_mulb%0d", i), 64'(seq[i]), 64'hFF);

      run_op("byte", 32'h1234_5678, 32'h0000_00FF, 64'h0000_0012_2222_2188, 2, 5, 1);
      check_eq("byte_mulb0", 64'(seq[0]), 64'hFF);

      run_op("top", 32'h0000_0003, 32'h0100_0000, 64'h0000_0000_0300_0000, 5, 5, 4);
      check_eq("top_mulb0", 64'(seq[0]), 64'h00);
      check_eq("top_mulb1", 64'(seq[1]), 64'h00);
      check_eq("top_mulb2", 64'(seq[2]), 64'h00);
      check_eq("top_mulb3", 64'(seq[3]), 64'h01);

      // Back-to-back with in_valid held high.
      hs1  = -1;
      acc2 = -1;
      outs = 0;
      p1   = '0;
      p2   = '0;
      @(negedge clk);
      in_a      = 32'd2;
      in_b      = 32'd5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 40 && outs < 2; i++) begin
         @(negedge clk);
         if (bus_s.out_valid) begin
            if (outs == 0) begin
               p1   = bus_s.out_p;
               hs1  = i + 1;
               in_a = 32'h0001_0000;
               in_b = 32'h0001_0000;
            end else begin
               p2       = bus_s.out_p;
               in_valid = 1'b0;
            end
            outs++;
         end else if (outs == 1 && bus_s.in_ready && acc2 < 0) begin
            acc2 = i + 1;
         end
      end
      in_valid = 1'b0;
      check_eq("b2b_outs", 64'(outs), 64'd2);
      check_eq("b2b_p1", p1, 64'd10);
      check_eq("b2b_p2", p2, 64'h0000_0001_0000_0000);
      check_eq("b2b_gap", 64'(acc2 - hs1), 64'd1);
      repeat (12) @(negedge clk);

      // B=0 result held under backpressure; in_valid pulses must be ignored.
      in_a      = 32'hDEAD_BEEF;
      in_b      = 32'd0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("hold_valid0", 64'(bus_s.out_valid), 64'd1);
      check_eq("hold_p0", bus_s.out_p, 64'd0);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_a     = 32'd5;
         in_b     = 32'd5;
         @(negedge clk);
         check_eq($sformatf("hold_valid_%0d", i), 64'(bus_s.out_valid), 64'd1);
         check_eq($sformatf("hold_p_%0d", i), bus_s.out_p, 64'd0);
         check_eq($sformatf("hold_in_ready_%0d", i), 64'(bus_s.in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("hold_release_valid", 64'(bus_s.out_valid), 64'd0);
      check_eq("hold_release_ready", 64'(bus_s.in_ready), 64'd1);
      check_eq("hold_retain_p", bus_s.out_p, 64'd0);
      repeat (3) @(negedge clk);
      check_eq("hold_no_capture", 64'(busy_s), 64'd0);

      // Reset in the middle of a run.
      in_a     = 32'hFFFF_FFFF;
      in_b     = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("mid_mulb_pre", 64'(mul_b_s), 64'hFF);
      rst_n = 1'b0;
      #1;
      check_eq("mid_out_valid", 64'(bus_s.out_valid), 64'd0);
      check_eq("mid_busy", 64'(busy_s), 64'd0);
      check_eq("mid_mulb", 64'(mul_b_s), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("mid_in_ready", 64'(bus_s.in_ready), 64'd1);
      run_op("post_rst", 32'd7, 32'd9, 64'd63, 2, 5, 1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul32x32_slice_seq.md
Name: mul32x32_slice_seq

Overview:
- Sequential 32x32 unsigned multiplier controller that sits directly upstream of the 32x8 array multiplier.
- Slices the 32-bit B operand into 8-bit bytes and drives them, one per cycle, into the 32x8 multiplier.
- Consumes the multiplier's 40-bit partial products and shift-accumulates them into a 64-bit product.
- Presents operands and result through valid/ready handshakes.

Parameters:
- SKIP_ZERO, 1, when 1 the block terminates early once all unprocessed upper bytes of B are zero; when 0 it always runs 4 slices.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; equals (state==IDLE).
- in_a  in  32  multiplicand, unsigned.
- in_b  in  32  multiplier, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  64  product in_a*in_b.
- mul_a  out  32  to 32x8 multiplier A input.
- mul_b  out  8  to 32x8 multiplier B input.
- mul_y  in  40  from 32x8 multiplier Y output; combinational, valid in the same cycle.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, slice index idx=0, accumulator acc=0, a_reg=0, b_reg=0.
  - Output values during reset: out_valid=0, out_p=0, mul_a=0, mul_b=0, busy=0, in_ready=1.
- Applies mid-operation: any in-flight product is discarded with no partial output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; mul_b=0.
  - On in_valid&&in_ready: capture a_reg=in_a, b_reg=in_b; acc=0; idx=0; go to RUN.
- RUN (one slice per cycle):
  - mul_a=a_reg; mul_b=b_reg[8*idx+7:8*idx].
  - At the clock edge: acc <= acc + ({24'b0,mul_y} << 8*idx); idx <= idx+1.
  - Exit to DONE after the idx=3 cycle.
  - With SKIP_ZERO=1, also exit to DONE after the idx=k cycle if b_reg[31:8*(k+1)]==0.
- Width rules:
  - acc is 64 bits.
  - Max term is 40 bits shifted by 24, so 64 bits; the sum never overflows since a 32x32 product fits in 64 bits.
  - No truncation anywhere.
- DONE:
  - out_valid=1; out_p=acc, held stable while out_ready=0.
  - in_ready=0; in_valid is ignored.
  - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
  - out_p retains its value until the next DONE.
- Latency (accept edge = cycle 0):
  - Full run: out_valid is high from cycle 5.
  - Early exit after k+1 slices: out_valid is high from cycle k+2 (minimum 2, for B<256, including B=0).
- Throughput:
  - No overlap; the next accept is possible at the earliest one cycle after the output handshake.
  - Max rate is 1 product per 6 cycles for a full run.
- mul_a/mul_b are registered or derived from registers only (no combinational path from in_* to mul_*).
- in_a/in_b changes outside the accept cycle have no effect.

Test Plan:
- a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1:
  - out_p=0xFFFFFFFE00000001; out_valid rises at cycle 5.
  - mul_b sequence is 0xFF x4.
- a=0x12345678, b=0x000000FF, SKIP_ZERO=1:
  - One RUN cycle; out_p=0x0000001222222188; out_valid at cycle 2.
  - With SKIP_ZERO=0: same out_p, out_valid at cycle 5.
- a=0x00000003, b=0x01000000:
  - Four RUN cycles, mul_b sequence 00,00,00,01; out_p=0x0000000003000000.
- b=0, a=0xDEADBEEF:
  - out_p=0 at cycle 2.
  - Then hold out_ready=0 for 10 cycles: out_valid and out_p stay stable, in_ready=0, and pulsing in_valid causes no capture.
- Reset mid-RUN:
  - Assert rst_n=0 at idx=2: immediately out_valid=0, busy=0, mul_b=0.
  - After release, in_ready=1; a new op a=7, b=9 gives out_p=63.
- Back-to-back: in_valid held high, out_ready=1, ops (2,5) then (0x10000,0x10000):
  - Outputs are 10, then 0x0000000100000000.
  - Second accept occurs one cycle after the first output handshake.
